// File: rtl/freq_div_pkg.sv
// Shared types and constants for the divider tick generator.
// Select encodings, FSM states and divisor lookup.
package freq_div_pkg;

  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_DIV2 = 2'b01;
  localparam logic [1:0] SEL_DIV4 = 2'b10;
  localparam logic [1:0] SEL_DIV8 = 2'b11;

  localparam int DIV_BASE = 1;
  localparam int DIV_2    = 2;
  localparam int DIV_4    = 4;
  localparam int DIV_8    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic int divisor(input logic [1:0] s);
    int d;
    d = DIV_BASE;
    unique case (s)
      SEL_BASE: d = DIV_BASE;
      SEL_DIV2: d = DIV_2;
      SEL_DIV4: d = DIV_4;
      SEL_DIV8: d = DIV_8;
      default:  d = DIV_BASE;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/div_rise_detect.sv
// Rising-edge detector for a divider output sampled as data.
// prev follows din every cycle; rise is din high with prev low.
module div_rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic prev;

  // Keep last cycle's sample of the divider output
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev <= 1'b0;
    end else begin
      prev <= din;
    end
  end

  assign rise = din & ~prev;

endmodule

// File: rtl/div_clk_tick_gen.sv
// Selects a divider output, turns its rising edges into tick enables
// and strobes every period ticks. Watchdog: DIV_TICK_WATCHDOG_EN.
module div_clk_tick_gen
  import freq_div_pkg::*;
#(
  parameter int CNT_WIDTH    = 8,
  parameter int STALL_MARGIN = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [1:0]           sel,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic                 clk_div2,
  input  logic                 clk_div4,
  input  logic                 clk_div8,
  output logic                 tick,
  output logic                 strobe,
  output logic [CNT_WIDTH-1:0] tick_count,
  output logic                 busy,
  output logic                 err_stall
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  if (STALL_MARGIN < 1) begin : g_cfg_chk
    $error("STALL_MARGIN must be at least 1");
  end

  state_e               state;
  state_e               state_n;
  logic [1:0]           sel_l;
  logic [1:0]           sel_l_n;
  logic [CNT_WIDTH-1:0] period_l;
  logic [CNT_WIDTH-1:0] period_l_n;
  logic [CNT_WIDTH-1:0] cnt_n;
  logic                 tick_n;
  logic                 strobe_n;
  logic                 err_n;
  logic                 rise2;
  logic                 rise4;
  logic                 rise8;
  logic                 rise_sel;
  logic                 stall_hit;

  div_rise_detect u_rise2 (
    .clk   (clk),
    .reset (reset),
    .din   (clk_div2),
    .rise  (rise2)
  );

  div_rise_detect u_rise4 (
    .clk   (clk),
    .reset (reset),
    .din   (clk_div4),
    .rise  (rise4)
  );

  div_rise_detect u_rise8 (
    .clk   (clk),
    .reset (reset),
    .din   (clk_div8),
    .rise  (rise8)
  );

  // Pick the rise of the latched source; base rises every cycle
  always_comb begin
    rise_sel = 1'b1;
    unique case (sel_l)
      SEL_BASE: rise_sel = 1'b1;
      SEL_DIV2: rise_sel = rise2;
      SEL_DIV4: rise_sel = rise4;
      SEL_DIV8: rise_sel = rise8;
      default:  rise_sel = 1'b1;
    endcase
  end

`ifdef DIV_TICK_WATCHDOG_EN
  localparam int SW = $clog2(STALL_MARGIN * DIV_8 + 1);

  logic [SW-1:0] stall_cnt;
  logic [SW-1:0] stall_n;
  logic [SW-1:0] stall_lim;

  assign stall_lim = SW'(STALL_MARGIN * divisor(sel_l));

  // Count cycles since the last rise; fire at the limit
  always_comb begin
    stall_n   = stall_cnt;
    stall_hit = 1'b0;
    if (state == IDLE || !enable || rise_sel) begin
      stall_n = '0;
    end else if (sel_l != SEL_BASE) begin
      if (stall_cnt + SW'(1) == stall_lim) begin
        stall_hit = 1'b1;
        stall_n   = '0;
      end else begin
        stall_n = stall_cnt + SW'(1);
      end
    end
  end

  // Stall counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_n;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Next state and next outputs; disable beats a same-cycle rise
  always_comb begin
    state_n    = state;
    sel_l_n    = sel_l;
    period_l_n = period_l;
    cnt_n      = tick_count;
    tick_n     = 1'b0;
    strobe_n   = 1'b0;
    err_n      = err_stall;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (enable) begin
          sel_l_n    = sel;
          period_l_n = (period == '0) ? ONE : period;
          state_n    = SYNC;
        end
      end
      SYNC, RUN: begin
        if (!enable) begin
          state_n = IDLE;
          cnt_n   = '0;
          err_n   = 1'b0;
        end else if (rise_sel) begin
          state_n = RUN;
          tick_n  = 1'b1;
          if (tick_count == period_l - ONE) begin
            cnt_n    = '0;
            strobe_n = 1'b1;
          end else begin
            cnt_n = tick_count + ONE;
          end
        end else if (stall_hit) begin
          state_n = SYNC;
          cnt_n   = '0;
          err_n   = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Registered outputs and latched configuration
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_l      <= SEL_BASE;
      period_l   <= '0;
      tick_count <= '0;
      tick       <= 1'b0;
      strobe     <= 1'b0;
    end else begin
      sel_l      <= sel_l_n;
      period_l   <= period_l_n;
      tick_count <= cnt_n;
      tick       <= tick_n;
      strobe     <= strobe_n;
    end
  end

`ifdef DIV_TICK_WATCHDOG_EN
  // Sticky stall flag, cleared only by leaving SYNC/RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_stall <= 1'b0;
    end else begin
      err_stall <= err_n;
    end
  end
`else
  assign err_stall = 1'b0;
  logic unused_err;
  assign unused_err = err_n;
`endif

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_div_clk_tick_gen.sv
// Bench for div_clk_tick_gen: live divider, behavioural model,
// directed plan steps followed by randomized enable/sel/period.
module tb_div_clk_tick_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] sel;
  logic [7:0] period;
  logic       clk_div2;
  logic       clk_div4;
  logic       clk_div8;
  logic       tick;
  logic       strobe;
  logic [7:0] tick_count;
  logic       busy;
  logic       err_stall;

  div_clk_tick_gen #(.CNT_WIDTH(8), .STALL_MARGIN(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .sel        (sel),
    .period     (period),
    .clk_div2   (clk_div2),
    .clk_div4   (clk_div4),
    .clk_div8   (clk_div8),
    .tick       (tick),
    .strobe     (strobe),
    .tick_count (tick_count),
    .busy       (busy),
    .err_stall  (err_stall)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [2:0] dcnt;
  bit         hold8;

  bit       m_busy;
  int       m_sel;
  int       m_per;
  int       m_cnt;
  int       m_stall;
  bit       m_err;
  bit       e_tick;
  bit       e_strobe;
  bit [2:0] m_prev;

  int nt;
  int ns;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_div();
    clk_div2 = dcnt[0];
    clk_div4 = dcnt[1];
    clk_div8 = hold8 ? 1'b0 : dcnt[2];
  endtask

  task automatic model_reset();
    m_busy   = 0;
    m_sel    = 0;
    m_per    = 0;
    m_cnt    = 0;
    m_stall  = 0;
    m_err    = 0;
    e_tick   = 0;
    e_strobe = 0;
    m_prev   = '0;
  endtask

  // One clock of the reference behaviour, from sampled inputs
  task automatic model_step();
    bit [2:0] cur;
    bit       r;
    cur = {clk_div8, clk_div4, clk_div2};
    r = (m_sel == 0) ? 1'b1 : (cur[m_sel-1] && !m_prev[m_sel-1]);
    e_tick   = 0;
    e_strobe = 0;
    if (!m_busy) begin
      m_cnt = 0;
      if (enable) begin
        m_busy  = 1;
        m_sel   = int'(sel);
        m_per   = (period == 0) ? 1 : int'(period);
        m_stall = 0;
      end
    end else if (!enable) begin
      m_busy = 0;
      m_cnt  = 0;
      m_err  = 0;
    end else if (r) begin
      e_tick   = 1;
      m_cnt    = (m_cnt + 1) % m_per;
      e_strobe = (m_cnt == 0);
      m_stall  = 0;
    end else begin
`ifdef DIV_TICK_WATCHDOG_EN
      if (m_sel != 0) begin
        m_stall++;
        if (m_stall >= 2 * (1 << m_sel)) begin
          m_err   = 1;
          m_cnt   = 0;
          m_stall = 0;
        end
      end
`endif
    end
    m_prev = cur;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("tick", 32'(tick), 32'(e_tick));
    chk("strobe", 32'(strobe), 32'(e_strobe));
    chk("tick_count", 32'(tick_count), m_cnt);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("err_stall", 32'(err_stall), 32'(m_err));
    nt += int'(tick);
    ns += int'(strobe);
    dcnt = dcnt + 3'd1;
    drive_div();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    bit found;
    reset  = 1'b1;
    enable = 1'b0;
    sel    = 2'b00;
    period = 8'd0;
    dcnt   = '0;
    hold8  = 0;
    nt     = 0;
    ns     = 0;
    drive_div();
    model_reset();
    #7;
    chk("rst_tick", 32'(tick), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(tick_count), 0);
    #5 reset = 1'b0;
    run(3);

    // div4, period 3
    sel = 2'b10; period = 8'd3; enable = 1'b1;
    run(16);
    nt = 0; ns = 0;
    run(24);
    chk("div4_ticks", nt, 6);
    chk("div4_strobes", ns, 2);

    // async reset mid-RUN, checked before the next edge
    #2 reset = 1'b1;
    #1;
    chk("arst_tick", 32'(tick), 0);
    chk("arst_strobe", 32'(strobe), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_err", 32'(err_stall), 0);
    chk("arst_count", 32'(tick_count), 0);
    model_reset();
    enable = 1'b0;
    dcnt = '0;
    drive_div();
    #1 reset = 1'b0;
    run(2);

    // div2, period 0 behaves as 1
    sel = 2'b01; period = 8'd0; enable = 1'b1;
    run(10);
    nt = 0; ns = 0;
    run(20);
    chk("div2_ticks", nt, 10);
    chk("div2_strobes", ns, 10);
    enable = 1'b0;
    run(2);

    // base select; changes while busy are ignored
    sel = 2'b00; period = 8'd5; enable = 1'b1;
    run(12);
    sel = 2'b11; period = 8'd2;
    nt = 0; ns = 0;
    run(20);
    chk("base_ticks", nt, 20);
    chk("base_strobes", ns, 4);
    enable = 1'b0;
    run(1);
    enable = 1'b1;
    run(16);
    nt = 0; ns = 0;
    run(32);
    chk("relatch_ticks", nt, 4);
    chk("relatch_strobes", ns, 2);
    enable = 1'b0;
    run(2);

    // stall: div8 held low after the first tick
    sel = 2'b11; period = 8'd4; enable = 1'b1;
    found = 0;
    for (int i = 0; i < 24 && !found; i++) begin
      cycle();
      if (tick === 1'b1) found = 1;
    end
    chk("stall_first_tick", 32'(found), 1);
    hold8 = 1;
    drive_div();
    run(20);
`ifdef DIV_TICK_WATCHDOG_EN
    chk("stall_err", 32'(err_stall), 1);
    chk("stall_busy", 32'(busy), 1);
    chk("stall_count", 32'(tick_count), 0);
`else
    chk("stall_err_off", 32'(err_stall), 0);
`endif
    hold8 = 0;
    drive_div();
    enable = 1'b0;
    run(1);
    chk("stall_clear", 32'(err_stall), 0);
    run(1);

    // deassert on the same cycle as a div8 rise
    sel = 2'b11; period = 8'd2; enable = 1'b1;
    run(3);
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      cycle();
      if (dcnt == 3'd4 && clk_div8 && !m_prev[2]) found = 1;
    end
    chk("coll_found", 32'(found), 1);
    enable = 1'b0;
    cycle();
    chk("coll_tick", 32'(tick), 0);
    chk("coll_busy", 32'(busy), 0);
    chk("coll_count", 32'(tick_count), 0);

    // randomized enable/sel/period/stall traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) begin
        enable = ~enable;
        sel    = 2'($urandom_range(0, 3));
        period = 8'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 9) == 0) begin
        sel    = 2'($urandom_range(0, 3));
        period = 8'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 49) == 0) begin
        hold8 = ~hold8;
        drive_div();
      end
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
